// File: rtl/rom_loader_sdram.sv
// Packs the byte-wide ioctl ROM download into 16-bit little-endian words, queues them in a small
// FIFO and writes them to SDRAM, holding the CPU in reset for the duration of the load.
module rom_loader_sdram #(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [24:0] ADDR_BASE  = 25'h0000000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [20:0] MAX_WORDS  = 21'h100000
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        sdram_wr,
  input  logic        sdram_wr_rdy,
  output logic [24:0] sdram_waddr,
  output logic [15:0] sdram_din,
  output logic        hold_cpu,
  output logic        load_done,
  output logic [20:0] load_words,
  output logic        overflow,
  output logic [2:0]  dbg_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {L_IDLE, L_LOADING, L_FLUSH, L_DONE} lstate_t;
  typedef enum logic {W_IDLE, W_REQ} wstate_t;
  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } entry_t;

  // Handshake: sdram_wr rises with address/data and holds them steady until the cycle
  // sdram_wr_rdy is seen high; that cycle is the accept and the head entry is popped.
  lstate_t     lstate_q;
  wstate_t     wstate_q;
  entry_t      fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_lo_q, pend_lo_d;
  logic [23:0] pend_w_q, pend_w_d;
  logic        dl_q;
  logic        push0, push1, pop, ovf_set, active_byte, flush, load_start, in_range;
  entry_t      e0, e1;
  logic [23:0] w;

  function automatic entry_t mk(input logic [23:0] wa, input logic [15:0] d);
    entry_t e;
    e.addr = ADDR_BASE + {wa, 1'b0};
    e.data = d;
    return e;
  endfunction

  assign w           = ioctl_addr[24:1];
  assign in_range    = w < {3'b000, MAX_WORDS};
  assign active_byte = ioctl_wr && ioctl_download && (ioctl_index == ROM_INDEX) && (lstate_q == L_LOADING);
  assign flush       = (lstate_q == L_LOADING) && !ioctl_download;
  assign load_start  = (lstate_q == L_IDLE) && ioctl_download && !dl_q && (ioctl_index == ROM_INDEX);
  assign pop         = (wstate_q == W_REQ) && sdram_wr_rdy;
  assign wr_ptr_nxt  = wr_ptr_q + 1'b1;
  assign count_d     = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  assign ioctl_wait  = (CW'(FIFO_DEPTH) - count_q) < CW'(2);
  assign dbg_state_o = {wstate_q, lstate_q};

  always_comb begin
    push0     = 1'b0;
    push1     = 1'b0;
    e0        = '0;
    e1        = '0;
    ovf_set   = 1'b0;
    pend_d    = pend_q;
    pend_lo_d = pend_lo_q;
    pend_w_d  = pend_w_q;
    if (active_byte) begin
      if (!in_range) begin
        ovf_set = 1'b1;
      end else if (!ioctl_addr[0]) begin
        // A new even byte evicts any older pending byte as a half-filled word.
        if (pend_q) begin
          push0 = 1'b1;
          e0    = mk(pend_w_q, {8'h00, pend_lo_q});
        end
        pend_d    = 1'b1;
        pend_lo_d = ioctl_dout;
        pend_w_d  = w;
      end else begin
        if (pend_q && pend_w_q == w) begin
          push0 = 1'b1;
          e0    = mk(w, {ioctl_dout, pend_lo_q});
        end else if (pend_q) begin
          push0 = 1'b1;
          e0    = mk(pend_w_q, {8'h00, pend_lo_q});
          push1 = 1'b1;
          e1    = mk(w, {ioctl_dout, 8'h00});
        end else begin
          push0 = 1'b1;
          e0    = mk(w, {ioctl_dout, 8'h00});
        end
        pend_d = 1'b0;
      end
    end else if (flush && pend_q) begin
      push0  = 1'b1;
      e0     = mk(pend_w_q, {8'h00, pend_lo_q});
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push0) fifo_q[wr_ptr_q] <= e0;
    if (push1) fifo_q[wr_ptr_nxt] <= e1;
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_lo_q <= '0;
      pend_w_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + PW'(push0) + PW'(push1);
      rd_ptr_q  <= rd_ptr_q + PW'(pop);
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_lo_q <= pend_lo_d;
      pend_w_q  <= pend_w_d;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      lstate_q  <= L_IDLE;
      hold_cpu  <= 1'b0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
      case (lstate_q)
        L_IDLE: if (load_start) begin
          lstate_q <= L_LOADING;
          hold_cpu <= 1'b1;
          overflow <= 1'b0;
        end
        L_LOADING: if (!ioctl_download) lstate_q <= L_FLUSH;
        L_FLUSH: if (count_q == '0 && !sdram_wr) begin
          lstate_q  <= L_DONE;
          load_done <= 1'b1;
        end
        L_DONE: begin
          hold_cpu <= 1'b0;
          lstate_q <= L_IDLE;
        end
        default: lstate_q <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      wstate_q    <= W_IDLE;
      sdram_wr    <= 1'b0;
      sdram_waddr <= '0;
      sdram_din   <= '0;
      load_words  <= '0;
    end else begin
      if (load_start) load_words <= '0;
      else if (pop && load_words != MAX_WORDS) load_words <= load_words + 1'b1;
      case (wstate_q)
        W_IDLE: if (count_q != '0) begin
          sdram_waddr <= fifo_q[rd_ptr_q].addr;
          sdram_din   <= fifo_q[rd_ptr_q].data;
          sdram_wr    <= 1'b1;
          wstate_q    <= W_REQ;
        end
        W_REQ: if (sdram_wr_rdy) begin
          sdram_wr <= 1'b0;
          wstate_q <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_loader_sdram.sv
// Bench for rom_loader_sdram: table-driven packing vectors plus hand sequences for stalls,
// odd-length loads, foreign index, overflow (second instance with MAX_WORDS=2) and mid-load reset.
module tb_rom_loader_sdram;
  logic        cpu_clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, sdram_wr, hold_cpu, load_done, overflow;
  logic        sdram_wr_rdy = 1'b0;
  logic [24:0] sdram_waddr;
  logic [15:0] sdram_din;
  logic [20:0] load_words;
  logic [2:0]  dbg_state;

  logic        ioctl_wait2, sdram_wr2, hold_cpu2, load_done2, overflow2;
  logic        sdram_wr_rdy2 = 1'b0;
  logic [24:0] sdram_waddr2;
  logic [15:0] sdram_din2;
  logic [20:0] load_words2;
  logic [2:0]  dbg_state2;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr2_cnt = 0;
  logic stall = 1'b0;
  logic [40:0] exp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  rom_loader_sdram dut (
    .cpu_clk(cpu_clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .sdram_wr(sdram_wr), .sdram_wr_rdy(sdram_wr_rdy), .sdram_waddr(sdram_waddr), .sdram_din(sdram_din),
    .hold_cpu(hold_cpu), .load_done(load_done), .load_words(load_words), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  rom_loader_sdram #(.MAX_WORDS(21'd2)) dut2 (
    .cpu_clk(cpu_clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait2),
    .sdram_wr(sdram_wr2), .sdram_wr_rdy(sdram_wr_rdy2), .sdram_waddr(sdram_waddr2), .sdram_din(sdram_din2),
    .hold_cpu(hold_cpu2), .load_done(load_done2), .load_words(load_words2), .overflow(overflow2),
    .dbg_state_o(dbg_state2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model for dut: accepts one cycle after the request is seen, unless stalled.
  always @(negedge cpu_clk) begin
    if (reset) begin
      sdram_wr_rdy = 1'b0;
    end else if (sdram_wr && !sdram_wr_rdy && !stall) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %0h expected none", {sdram_waddr, sdram_din});
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        if ({sdram_waddr, sdram_din} !== e) begin
          n_err++;
          $display("FAIL sdram_write: got %0h expected %0h", {sdram_waddr, sdram_din}, e);
        end
      end
      wr_cnt++;
      sdram_wr_rdy = 1'b1;
    end else begin
      sdram_wr_rdy = 1'b0;
    end
  end

  always @(negedge cpu_clk) begin
    if (reset) sdram_wr_rdy2 = 1'b0;
    else if (sdram_wr2 && !sdram_wr_rdy2) begin
      wr2_cnt++;
      sdram_wr_rdy2 = 1'b1;
    end else sdram_wr_rdy2 = 1'b0;
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    while (ioctl_wait && t < 300) begin
      @(negedge cpu_clk);
      t++;
    end
    if (t >= 300) check("ioctl_wait_timeout", 64'(ioctl_wait), 64'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge cpu_clk);
    ioctl_wr = 1'b0;
    @(negedge cpu_clk);
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check("hold_cpu_at_start", 64'(hold_cpu), (idx == 8'd0) ? 64'd1 : 64'd0);
  endtask

  task automatic end_load(input int exp_words);
    int t = 0;
    check("hold_cpu_during_load", 64'(hold_cpu), 64'd1);
    ioctl_download = 1'b0;
    @(negedge cpu_clk);
    while (!load_done && t < 400) begin
      @(negedge cpu_clk);
      t++;
    end
    check("load_done_seen", 64'(load_done), 64'd1);
    check("load_words", 64'(load_words), 64'(exp_words));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    @(negedge cpu_clk);
    check("load_done_one_cycle", 64'(load_done), 64'd0);
    check("hold_cpu_released", 64'(hold_cpu), 64'd0);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  b;
    int          n;
    logic [40:0] e0;
    logic [40:0] e1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sb[16];
    int c, c2;

    tbl[0] = '{25'd0,  8'h11, 0, 41'h0, 41'h0};
    tbl[1] = '{25'd1,  8'h22, 1, {25'h0, 16'h2211}, 41'h0};
    tbl[2] = '{25'd2,  8'h33, 0, 41'h0, 41'h0};
    tbl[3] = '{25'd3,  8'h44, 1, {25'h2, 16'h4433}, 41'h0};
    tbl[4] = '{25'd5,  8'h55, 1, {25'h4, 16'h5500}, 41'h0};
    tbl[5] = '{25'd6,  8'h66, 0, 41'h0, 41'h0};
    tbl[6] = '{25'd9,  8'h77, 2, {25'h6, 16'h0066}, {25'h8, 16'h7700}};
    tbl[7] = '{25'd10, 8'h88, 0, 41'h0, 41'h0};
    tbl[8] = '{25'd12, 8'h99, 1, {25'hA, 16'h0088}, 41'h0};
    tbl[9] = '{25'd13, 8'hAA, 1, {25'hC, 16'hAA99}, 41'h0};

    repeat (3) @(negedge cpu_clk);
    check("reset_outputs",
          64'({ioctl_wait, sdram_wr, hold_cpu, load_done, load_words, overflow}), 64'd0);
    reset = 1'b0;
    @(negedge cpu_clk);

    // Packing table: in-order pairs, lone odd, split pair, even-while-pending.
    start_load(8'd0);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].n > 0) exp_q.push_back(tbl[i].e0);
      if (tbl[i].n > 1) exp_q.push_back(tbl[i].e1);
      send_byte(tbl[i].addr, tbl[i].b);
    end
    end_load(7);

    // Odd-length load: last byte flushed as a zero-padded word.
    start_load(8'd0);
    exp_q.push_back({25'h0, 16'hBBAA});
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    exp_q.push_back({25'h2, 16'h00CC});
    end_load(2);

    // SDRAM stalled for 100 cycles during a 16-byte stream.
    for (int i = 0; i < 16; i++) sb[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 16; i += 2) exp_q.push_back({25'(i), sb[i+1], sb[i]});
    start_load(8'd0);
    stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send_byte(25'(i), sb[i]);
      end
      begin
        repeat (100) @(negedge cpu_clk);
        check("ioctl_wait_when_3_used", 64'(ioctl_wait), 64'd1);
        check("sdram_wr_held", 64'(sdram_wr), 64'd1);
        check("sdram_waddr_held", 64'(sdram_waddr), 64'd0);
        check("sdram_din_held", 64'(sdram_din), 64'({sb[1], sb[0]}));
        stall = 1'b0;
      end
    join
    end_load(8);

    // Foreign index: nothing written, CPU never held.
    c  = wr_cnt;
    c2 = wr2_cnt;
    start_load(8'd1);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'h40 + i));
    ioctl_download = 1'b0;
    repeat (20) @(negedge cpu_clk);
    check("idx1_no_writes", 64'(wr_cnt - c), 64'd0);
    check("idx1_no_writes_dut2", 64'(wr2_cnt - c2), 64'd0);
    check("idx1_hold_cpu", 64'(hold_cpu), 64'd0);

    // Overflow: dut2 (MAX_WORDS=2) keeps two words, dut takes all three.
    c2 = wr2_cnt;
    start_load(8'd0);
    exp_q.push_back({25'h0, 16'h0201});
    exp_q.push_back({25'h2, 16'h0403});
    exp_q.push_back({25'h4, 16'h0605});
    for (int i = 0; i < 6; i++) send_byte(25'(i), 8'(i + 1));
    end_load(3);
    repeat (5) @(negedge cpu_clk);
    check("ovf_dut2_writes", 64'(wr2_cnt - c2), 64'd2);
    check("ovf_dut2_flag", 64'(overflow2), 64'd1);
    check("ovf_dut2_load_words", 64'(load_words2), 64'd2);
    check("ovf_dut2_hold_released", 64'(hold_cpu2), 64'd0);
    check("ovf_dut_flag_clear", 64'(overflow), 64'd0);

    // Reset while a request is outstanding, then a fresh load.
    start_load(8'd0);
    exp_q.push_back({25'h0, 16'h2211});
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    repeat (8) @(negedge cpu_clk);
    check("pre_reset_load_words", 64'(load_words), 64'd1);
    stall = 1'b1;
    send_byte(25'd2, 8'h33);
    send_byte(25'd3, 8'h44);
    c = 0;
    while (!sdram_wr && c < 20) begin
      @(negedge cpu_clk);
      c++;
    end
    check("pre_reset_wr_high", 64'(sdram_wr), 64'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge cpu_clk);
    check("reset_drops_wr", 64'(sdram_wr), 64'd0);
    check("reset_drops_hold", 64'(hold_cpu), 64'd0);
    check("reset_clears_words", 64'(load_words), 64'd0);
    reset = 1'b0;
    stall = 1'b0;
    exp_q.delete();
    @(negedge cpu_clk);
    start_load(8'd0);
    exp_q.push_back({25'h0, 16'hCDAB});
    send_byte(25'd0, 8'hAB);
    send_byte(25'd1, 8'hCD);
    end_load(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
